// File: rtl/nfc_page_checker_if.sv
// Beat-stream bundle for the NFC page checker: readback and golden streams
// sharing one ready signal. Master drives the streams, slave is the checker.
`timescale 1ns/1ps
interface nfc_page_checker_if #(
    parameter int DATA_W = 8
);
    logic              act_valid;
    logic [DATA_W-1:0] act_data;
    logic              exp_valid;
    logic [DATA_W-1:0] exp_data;
    logic              in_ready;

    modport master (
        output act_valid, act_data, exp_valid, exp_data,
        input  in_ready
    );

    modport slave (
        input  act_valid, act_data, exp_valid, exp_data,
        output in_ready
    );
endinterface

// File: rtl/nfc_page_checker.sv
// NAND copy-path self-check engine: compares destination-flash readback with
// golden data page by page and reports per-page and whole-run verdicts.
// Optional mismatch log FIFO is built when NFC_CHK_ERR_LOG_EN is defined;
// LOG_DEPTH must then be a power of two and at least 2.
`timescale 1ns/1ps
module nfc_page_checker #(
    parameter int DATA_W     = 8,
    parameter int PAGE_BYTES = 512,
    parameter int NUM_PAGES  = 512,
    parameter int ERR_W      = 16,
    parameter int LOG_DEPTH  = 4,
    localparam int ADDR_W    = $clog2(PAGE_BYTES * NUM_PAGES),
    localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1,
    localparam int OFF_W     = $clog2(PAGE_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    nfc_page_checker_if.slave bus,
    output logic              busy_o,
    output logic              page_done_o,
    output logic [PAGE_W-1:0] page_idx_o,
    output logic              page_pass_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [ADDR_W-1:0] first_err_addr_o,
    output logic              first_err_vld_o,
    output logic              done_o,
    output logic              pass_o
`ifdef NFC_CHK_ERR_LOG_EN
    ,
    input  logic              log_rd_i,
    output logic              log_valid_o,
    output logic [ADDR_W-1:0] log_addr_o,
    output logic [DATA_W-1:0] log_act_o,
    output logic [DATA_W-1:0] log_exp_o,
    output logic              log_ovf_o
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGE_BYTES * NUM_PAGES - 1);
    localparam logic [OFF_W-1:0]  LAST_OFF  = OFF_W'(PAGE_BYTES - 1);
    localparam logic [PAGE_W-1:0] LAST_PAGE = PAGE_W'(NUM_PAGES - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [PAGE_W-1:0] page_q, page_d;
    logic              pageErr_q, pageErr_d;
    logic [ERR_W-1:0]  errCnt_q, errCnt_d;
    logic [ADDR_W-1:0] firstAddr_q, firstAddr_d;
    logic              firstVld_q, firstVld_d;
    logic              pageDone_q, pageDone_d;
    logic [PAGE_W-1:0] pageIdx_q, pageIdx_d;
    logic              pagePass_q, pagePass_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              beatAcc;
    logic              beatMis;
    logic              runInit;

    assign beatAcc      = (state_q == RUN) & bus.act_valid & bus.exp_valid;
    assign bus.in_ready = beatAcc;

    // Mismatch detect; the else path also catches X/Z compare results
    always_comb begin
        beatMis = 1'b1;
        if (bus.act_data == bus.exp_data) beatMis = 1'b0;
    end

    // Run FSM plus address, page, error and verdict next-state logic
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        page_d      = page_q;
        pageErr_d   = pageErr_q;
        errCnt_d    = errCnt_q;
        firstAddr_d = firstAddr_q;
        firstVld_d  = firstVld_q;
        pageDone_d  = 1'b0;
        pageIdx_d   = pageIdx_q;
        pagePass_d  = pagePass_q;
        done_d      = done_q;
        pass_d      = pass_q;
        runInit     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = RUN;
                    runInit     = 1'b1;
                    addr_d      = '0;
                    page_d      = '0;
                    pageErr_d   = 1'b0;
                    errCnt_d    = '0;
                    firstAddr_d = '0;
                    firstVld_d  = 1'b0;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                end
            end
            RUN: begin
                if (beatAcc) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (beatMis) begin
                        pageErr_d = 1'b1;
                        if (errCnt_q != {ERR_W{1'b1}}) errCnt_d = errCnt_q + ERR_W'(1);
                        if (!firstVld_q) begin
                            firstVld_d  = 1'b1;
                            firstAddr_d = addr_q;
                        end
                    end
                    if (addr_q[OFF_W-1:0] == LAST_OFF) begin
                        pageDone_d = 1'b1;
                        pageIdx_d  = page_q;
                        pagePass_d = !(pageErr_q | beatMis);
                        pageErr_d  = 1'b0;
                        page_d     = (page_q == LAST_PAGE) ? '0 : page_q + PAGE_W'(1);
                    end
                    if (addr_q == LAST_ADDR) begin
                        state_d = DONE;
                        addr_d  = '0;
                        done_d  = 1'b1;
                        pass_d  = (errCnt_q == '0) & !beatMis;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared by the asynchronous reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            page_q      <= '0;
            pageErr_q   <= 1'b0;
            errCnt_q    <= '0;
            firstAddr_q <= '0;
            firstVld_q  <= 1'b0;
            pageDone_q  <= 1'b0;
            pageIdx_q   <= '0;
            pagePass_q  <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            page_q      <= page_d;
            pageErr_q   <= pageErr_d;
            errCnt_q    <= errCnt_d;
            firstAddr_q <= firstAddr_d;
            firstVld_q  <= firstVld_d;
            pageDone_q  <= pageDone_d;
            pageIdx_q   <= pageIdx_d;
            pagePass_q  <= pagePass_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

    assign busy_o           = (state_q == RUN);
    assign page_done_o      = pageDone_q;
    assign page_idx_o       = pageIdx_q;
    assign page_pass_o      = pagePass_q;
    assign err_cnt_o        = errCnt_q;
    assign first_err_addr_o = firstAddr_q;
    assign first_err_vld_o  = firstVld_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;

`ifdef NFC_CHK_ERR_LOG_EN
    localparam int LOG_W = $clog2(LOG_DEPTH);

    logic [ADDR_W-1:0] logAddrMem [LOG_DEPTH];
    logic [DATA_W-1:0] logActMem  [LOG_DEPTH];
    logic [DATA_W-1:0] logExpMem  [LOG_DEPTH];
    logic [LOG_W-1:0]  wrPtr_q, rdPtr_q;
    logic [LOG_W:0]    count_q;
    logic              ovf_q;
    logic              logPush, logPop, logFull, pushOk;

    assign logPush = beatAcc & beatMis;
    assign logPop  = log_rd_i & (count_q != '0);
    assign logFull = (count_q == (LOG_W + 1)'(LOG_DEPTH));
    assign pushOk  = logPush & (!logFull | logPop);

    // FIFO pointers, occupancy and sticky overflow; a new run flushes all
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (runInit) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (pushOk) wrPtr_q <= wrPtr_q + LOG_W'(1);
            if (logPop) rdPtr_q <= rdPtr_q + LOG_W'(1);
            case ({pushOk, logPop})
                2'b10:   count_q <= count_q + (LOG_W + 1)'(1);
                2'b01:   count_q <= count_q - (LOG_W + 1)'(1);
                default: count_q <= count_q;
            endcase
            if (logPush & !pushOk) ovf_q <= 1'b1;
        end
    end

    // Log storage; only the write slot changes, so no reset is needed
    always_ff @(posedge clk_i) begin
        if (pushOk) begin
            logAddrMem[wrPtr_q] <= addr_q;
            logActMem[wrPtr_q]  <= bus.act_data;
            logExpMem[wrPtr_q]  <= bus.exp_data;
        end
    end

    assign log_valid_o = (count_q != '0);
    assign log_addr_o  = log_valid_o ? logAddrMem[rdPtr_q] : '0;
    assign log_act_o   = log_valid_o ? logActMem[rdPtr_q]  : '0;
    assign log_exp_o   = log_valid_o ? logExpMem[rdPtr_q]  : '0;
    assign log_ovf_o   = ovf_q;
`endif

endmodule

// File: tb/tb_nfc_page_checker.sv
// Directed testbench for nfc_page_checker (PAGE_BYTES=4, NUM_PAGES=2, ERR_W=2).
// Log FIFO checks are compiled in when NFC_CHK_ERR_LOG_EN is defined.
`timescale 1ns/1ps
module tb_nfc_page_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy, pageDone, pagePass, firstVld, done, pass;
    logic [0:0] pageIdx;
    logic [1:0] errCnt;
    logic [2:0] firstAddr;
`ifdef NFC_CHK_ERR_LOG_EN
    logic       logRd, logValid, logOvf;
    logic [2:0] logAddr;
    logic [7:0] logAct, logExp;
`endif

    logic [7:0] actVec [8];
    logic [7:0] expVec [8];
    int         pdIdx  [4];
    logic       pdPass [4];
    int         pdCnt;
    int         passCnt;
    int         totalCnt;

    nfc_page_checker_if #(.DATA_W(8)) bus ();

    nfc_page_checker #(
        .DATA_W(8), .PAGE_BYTES(4), .NUM_PAGES(2), .ERR_W(2), .LOG_DEPTH(4)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .start_i(start),
        .bus(bus),
        .busy_o(busy),
        .page_done_o(pageDone),
        .page_idx_o(pageIdx),
        .page_pass_o(pagePass),
        .err_cnt_o(errCnt),
        .first_err_addr_o(firstAddr),
        .first_err_vld_o(firstVld),
        .done_o(done),
        .pass_o(pass)
`ifdef NFC_CHK_ERR_LOG_EN
        ,
        .log_rd_i(logRd),
        .log_valid_o(logValid),
        .log_addr_o(logAddr),
        .log_act_o(logAct),
        .log_exp_o(logExp),
        .log_ovf_o(logOvf)
`endif
    );

    // Free-running 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Issue a one-cycle start pulse
    task automatic startRun();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Drive beats first..last back to back and record page_done events
    task automatic applyStimulus(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.act_valid = 1'b1;
            bus.exp_valid = 1'b1;
            bus.act_data  = actVec[i];
            bus.exp_data  = expVec[i];
            @(posedge clk);
            #1;
            if (pageDone === 1'b1) begin
                if (pdCnt < 4) begin
                    pdIdx[pdCnt]  = int'(pageIdx);
                    pdPass[pdCnt] = pagePass;
                end
                pdCnt++;
            end
        end
        bus.act_valid = 1'b0;
        bus.exp_valid = 1'b0;
    endtask

    task automatic loadClean();
        for (int i = 0; i < 8; i++) begin
            actVec[i] = 8'(i);
            expVec[i] = 8'(i);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bus.act_valid = 1'b1;
        bus.exp_valid = 1'b1;
        bus.act_data  = 8'h00;
        bus.exp_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %0b want 0", busy); else passCnt++;
        totalCnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready: got %0b want 0", bus.in_ready); else passCnt++;
        totalCnt++; if (done !== 1'b0 || pass !== 1'b0) $display("[TB] FAIL reset_done_pass: got %0b/%0b want 0/0", done, pass); else passCnt++;
        totalCnt++; if (errCnt !== 2'd0 || firstVld !== 1'b0 || firstAddr !== 3'd0) $display("[TB] FAIL reset_err: got cnt %0d vld %0b addr %0d want 0/0/0", errCnt, firstVld, firstAddr); else passCnt++;
        totalCnt++; if (pageDone !== 1'b0 || pagePass !== 1'b0 || pageIdx !== 1'd0) $display("[TB] FAIL reset_page: got %0b/%0b/%0d want 0/0/0", pageDone, pagePass, pageIdx); else passCnt++;
        bus.act_valid = 1'b0;
        bus.exp_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        totalCnt++; if (busy !== 1'b0) $display("[TB] FAIL idle_no_start_busy: got %0b want 0", busy); else passCnt++;
    endtask

    task automatic test_clean_run();
        loadClean();
        startRun();
        totalCnt++; if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL clean_start: busy %0b done %0b want 1/0", busy, done); else passCnt++;
        pdCnt = 0;
        applyStimulus(0, 7);
        totalCnt++; if (pdCnt !== 2) $display("[TB] FAIL clean_pd_count: got %0d want 2", pdCnt); else passCnt++;
        totalCnt++; if (pdIdx[0] !== 0 || pdPass[0] !== 1'b1) $display("[TB] FAIL clean_page0: idx %0d pass %0b want 0/1", pdIdx[0], pdPass[0]); else passCnt++;
        totalCnt++; if (pdIdx[1] !== 1 || pdPass[1] !== 1'b1) $display("[TB] FAIL clean_page1: idx %0d pass %0b want 1/1", pdIdx[1], pdPass[1]); else passCnt++;
        totalCnt++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) $display("[TB] FAIL clean_end: done %0b pass %0b busy %0b want 1/1/0", done, pass, busy); else passCnt++;
        totalCnt++; if (errCnt !== 2'd0 || firstVld !== 1'b0) $display("[TB] FAIL clean_err: cnt %0d vld %0b want 0/0", errCnt, firstVld); else passCnt++;
        @(posedge clk);
        #1;
        totalCnt++; if (pageDone !== 1'b0 || done !== 1'b1) $display("[TB] FAIL clean_hold: page_done %0b done %0b want 0/1", pageDone, done); else passCnt++;
    endtask

    task automatic test_page_fail();
        loadClean();
        actVec[5] = 8'hFF;
        startRun();
        totalCnt++; if (done !== 1'b0 || pass !== 1'b0) $display("[TB] FAIL fail_run_init: done %0b pass %0b want 0/0", done, pass); else passCnt++;
        pdCnt = 0;
        applyStimulus(0, 7);
        totalCnt++; if (pdCnt !== 2 || pdPass[0] !== 1'b1 || pdPass[1] !== 1'b0) $display("[TB] FAIL fail_pages: cnt %0d pass %0b,%0b want 2 1,0", pdCnt, pdPass[0], pdPass[1]); else passCnt++;
        totalCnt++; if (errCnt !== 2'd1) $display("[TB] FAIL fail_err_cnt: got %0d want 1", errCnt); else passCnt++;
        totalCnt++; if (firstVld !== 1'b1 || firstAddr !== 3'd5) $display("[TB] FAIL fail_first_addr: vld %0b addr %0d want 1/5", firstVld, firstAddr); else passCnt++;
        totalCnt++; if (done !== 1'b1 || pass !== 1'b0) $display("[TB] FAIL fail_verdict: done %0b pass %0b want 1/0", done, pass); else passCnt++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 8; i++) begin
            actVec[i] = 8'(i + 16);
            expVec[i] = 8'(i + 16);
        end
        startRun();
        pdCnt = 0;
        applyStimulus(0, 0);
        bus.act_valid = 1'b0;
        bus.exp_valid = 1'b1;
        bus.exp_data  = expVec[1];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            totalCnt++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall_in_ready_%0d: got %0b want 0", k, bus.in_ready); else passCnt++;
        end
        bus.act_valid = 1'b1;
        bus.act_data  = actVec[1];
        #1;
        totalCnt++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL stall_resume_ready: got %0b want 1", bus.in_ready); else passCnt++;
        applyStimulus(1, 6);
        totalCnt++; if (pdCnt !== 1 || done !== 1'b0 || busy !== 1'b1) $display("[TB] FAIL stall_addr_hold: pd %0d done %0b busy %0b want 1/0/1", pdCnt, done, busy); else passCnt++;
        applyStimulus(7, 7);
        totalCnt++; if (pdCnt !== 2 || pdIdx[1] !== 1 || done !== 1'b1 || pass !== 1'b1) $display("[TB] FAIL stall_end: pd %0d idx %0d done %0b pass %0b want 2/1/1/1", pdCnt, pdIdx[1], done, pass); else passCnt++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 8; i++) begin
            expVec[i] = 8'(i);
            actVec[i] = (i < 6) ? (8'(i) ^ 8'hFF) : 8'(i);
        end
`ifdef NFC_CHK_ERR_LOG_EN
        logRd = 1'b0;
`endif
        startRun();
        pdCnt = 0;
        applyStimulus(0, 1);
        totalCnt++; if (errCnt !== 2'd2) $display("[TB] FAIL sat_mid: got %0d want 2", errCnt); else passCnt++;
        applyStimulus(2, 7);
        totalCnt++; if (errCnt !== 2'd3) $display("[TB] FAIL sat_cnt: got %0d want 3", errCnt); else passCnt++;
        totalCnt++; if (pdPass[0] !== 1'b0 || pdPass[1] !== 1'b0) $display("[TB] FAIL sat_pages: got %0b,%0b want 0,0", pdPass[0], pdPass[1]); else passCnt++;
        totalCnt++; if (firstAddr !== 3'd0 || firstVld !== 1'b1 || pass !== 1'b0) $display("[TB] FAIL sat_first: addr %0d vld %0b pass %0b want 0/1/0", firstAddr, firstVld, pass); else passCnt++;
`ifdef NFC_CHK_ERR_LOG_EN
        totalCnt++; if (logOvf !== 1'b1) $display("[TB] FAIL log_ovf: got %0b want 1", logOvf); else passCnt++;
        for (int k = 0; k < 4; k++) begin
            totalCnt++; if (logValid !== 1'b1 || logAddr !== 3'(k)) $display("[TB] FAIL log_pop_%0d: valid %0b addr %0d want 1/%0d", k, logValid, logAddr, k); else passCnt++;
            totalCnt++; if (logAct !== actVec[k] || logExp !== expVec[k]) $display("[TB] FAIL log_data_%0d: act %h exp %h want %h/%h", k, logAct, logExp, actVec[k], expVec[k]); else passCnt++;
            logRd = 1'b1;
            @(posedge clk);
            #1;
            logRd = 1'b0;
        end
        totalCnt++; if (logValid !== 1'b0) $display("[TB] FAIL log_empty: got %0b want 0", logValid); else passCnt++;
`endif
    endtask

    task automatic test_reset_midrun();
        loadClean();
        actVec[1] = 8'hAA;
        startRun();
        applyStimulus(0, 2);
        totalCnt++; if (busy !== 1'b1 || errCnt !== 2'd1) $display("[TB] FAIL midrun_pre: busy %0b cnt %0d want 1/1", busy, errCnt); else passCnt++;
        rst_n = 1'b0;
        #1;
        totalCnt++; if (busy !== 1'b0 || errCnt !== 2'd0 || firstVld !== 1'b0 || firstAddr !== 3'd0) $display("[TB] FAIL midrun_async: busy %0b cnt %0d vld %0b addr %0d want all 0", busy, errCnt, firstVld, firstAddr); else passCnt++;
        @(posedge clk);
        #1;
        totalCnt++; if (pageDone !== 1'b0 || done !== 1'b0 || pass !== 1'b0) $display("[TB] FAIL midrun_no_pulse: pd %0b done %0b pass %0b want 0/0/0", pageDone, done, pass); else passCnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        loadClean();
        startRun();
        pdCnt = 0;
        applyStimulus(0, 7);
        totalCnt++; if (pdCnt !== 2 || done !== 1'b1 || pass !== 1'b1 || errCnt !== 2'd0) $display("[TB] FAIL midrun_rerun: pd %0d done %0b pass %0b cnt %0d want 2/1/1/0", pdCnt, done, pass, errCnt); else passCnt++;
    endtask

    task automatic test_back_to_back();
        loadClean();
        startRun();
        pdCnt = 0;
        applyStimulus(0, 3);
        start = 1'b1;
        applyStimulus(4, 4);
        start = 1'b0;
        applyStimulus(5, 7);
        totalCnt++; if (pdCnt !== 2 || pdIdx[1] !== 1 || done !== 1'b1 || pass !== 1'b1) $display("[TB] FAIL b2b_ignore_start: pd %0d idx %0d done %0b pass %0b want 2/1/1/1", pdCnt, pdIdx[1], done, pass); else passCnt++;
        startRun();
        totalCnt++; if (busy !== 1'b1 || done !== 1'b0) $display("[TB] FAIL b2b_restart: busy %0b done %0b want 1/0", busy, done); else passCnt++;
        pdCnt = 0;
        applyStimulus(0, 7);
        totalCnt++; if (pdCnt !== 2 || pdIdx[0] !== 0 || done !== 1'b1 || pass !== 1'b1) $display("[TB] FAIL b2b_second: pd %0d idx %0d done %0b pass %0b want 2/0/1/1", pdCnt, pdIdx[0], done, pass); else passCnt++;
    endtask

    // Main sequence
    initial begin
        passCnt  = 0;
        totalCnt = 0;
        pdCnt    = 0;
`ifdef NFC_CHK_ERR_LOG_EN
        logRd = 1'b0;
`endif
        test_reset();
        test_clean_run();
        test_page_fail();
        test_stall();
        test_saturation();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/nfc_page_checker.md
Name: nfc_page_checker

Overview:
- Synthesizable self-check engine for the NAND-flash copy datapath (flash A -> NFC -> flash B).
- Consumes two byte streams per channel beat: the readback from the destination flash and the golden/expected data.
- Compares them page by page and reports per-page pass/fail, a running mismatch count, the first failing address and a final verdict.
- Generalises the bench-side memory compare into RTL: parametrised data width, page size and page count, plus a pass/fail summary usable on silicon.

Parameters:
- DATA_W, 8, byte-lane width of the compared data.
- PAGE_BYTES, 512, beats per page; power of two, >=2.
- NUM_PAGES, 512, pages per check run; >=1.
- ERR_W, 16, mismatch counter width; the counter saturates.
- LOG_DEPTH, 4, mismatch-log FIFO depth; power of two; used only with the optional feature.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from address 0.
- act_valid  in  1  readback beat valid.
- act_data  in  DATA_W  readback byte.
- exp_valid  in  1  expected beat valid.
- exp_data  in  DATA_W  expected byte.
- in_ready  out  1  beat accept; common to both streams.
- busy  out  1  high in RUN.
- page_done  out  1  one-cycle pulse after the last beat of each page.
- page_idx  out  clog2(NUM_PAGES)  index of the page just finished; valid with page_done.
- page_pass  out  1  no mismatch in that page; valid with page_done.
- err_cnt  out  ERR_W  mismatches so far in this run; saturating.
- first_err_addr  out  clog2(PAGE_BYTES*NUM_PAGES)  global beat address of the first mismatch.
- first_err_vld  out  1  first_err_addr holds a valid address.
- done  out  1  level; high from run end until the next start.
- pass  out  1  level; valid while done: err_cnt==0.

Behaviour:
- Reset: state IDLE; every output 0. The address, page and error counters are cleared. Reset asserted mid-run aborts the run immediately with no page_done or done pulse.
- States:
  - IDLE: start -> RUN.
  - RUN: the last beat of the last page is accepted -> DONE.
  - DONE: start -> RUN.
  - start while in RUN is ignored.
- Run initialisation (on start from IDLE or DONE): clear addr, page, err_cnt, first_err_vld, done and pass.
- Handshake: in_ready = (state==RUN) & act_valid & exp_valid. A beat is accepted when in_ready is high. If only one stream is valid, no beat is accepted and the valid stream holds its data.
- Compare: a beat mismatches when act_data != exp_data. X or Z bits count as mismatches in simulation.
- Address: addr increments per accepted beat; the in-page offset is addr[clog2(PAGE_BYTES)-1:0].
- Page close: on acceptance of offset PAGE_BYTES-1, page_done pulses on the next cycle. page_pass = !(page-local error flag | current beat mismatch). The page-local error flag then clears.
- err_cnt: increments by 1 per mismatching beat; holds at 2^ERR_W-1.
- First error: first_err_addr and first_err_vld latch only on the first mismatch of the run.
- End of run: after the last beat (addr == PAGE_BYTES*NUM_PAGES-1), the following cycle asserts page_done for the final page, done=1 and pass=(err_cnt==0). The address wraps to 0. busy deasserts in that same cycle.
- Latency: one cycle from beat acceptance to visible err_cnt, page_done and done.

Optional Feature:
- Macro: NFC_CHK_ERR_LOG_EN.
- When defined:
  - Extra ports: log_rd in 1; log_valid out 1; log_addr out addr width; log_act and log_exp out DATA_W; log_ovf out 1.
  - Each mismatch pushes {addr, act, exp} into a LOG_DEPTH FIFO.
  - When the FIFO is full, the push is dropped and log_ovf sets sticky until start.
  - log_rd with log_valid pops; output is first-word-fall-through.
  - A push and a pop in the same cycle while full both succeed.
  - start flushes the FIFO.
- When undefined: no extra ports, no FIFO logic; core behaviour is identical.

Test Plan:
- PAGE_BYTES=4, NUM_PAGES=2: start, 8 matching beats 0x00..0x07 -> two page_done pulses (idx 0, 1, page_pass=1); done=1, pass=1, err_cnt=0, first_err_vld=0.
- Same config, act beat 5 = 0xFF vs exp 0x05 -> page 0 pass=1, page 1 pass=0; err_cnt=1; first_err_addr=5; pass=0.
- act_valid held low for 3 cycles while exp_valid=1 -> in_ready=0 throughout, addr unchanged; the beat is accepted when act_valid rises.
- ERR_W=2, 6 mismatching beats -> err_cnt saturates at 3.
- Reset asserted after 3 beats -> all outputs 0 asynchronously; a following start completes a clean 8-beat run with pass=1.
- NFC_CHK_ERR_LOG_EN, LOG_DEPTH=4, 6 mismatches with no reads -> log_ovf=1; 4 pops return addrs 0..3 in order; then log_valid=0.
